game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The module SHALL provide parameter COUNTDOWN_FRAMES, default 180, frames spent in COUNTDOWN before PLAY.
REQ-002 The module SHALL provide parameter OBSTACLE_FRAMES, default 300, frames each obstacle pattern stays active.
REQ-003 The module SHALL provide parameter NUM_OBSTACLES, default 4, number of obstacle patterns (2..8).
REQ-004 The module SHALL have port pclk, input, 1, pixel clock; the only clock.
REQ-005 The module SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 The module SHALL have port vsync_in, input, 1, VGA vsync from timing chain.
REQ-007 The module SHALL have ports game_button and menu_button, input, 1 each, raw asynchronous push-buttons.
REQ-008 The module SHALL have port play_selected, input, 1, menu "play" item clicked.
REQ-009 The module SHALL have port collision, input, 1, player hit obstacle, sampled in PLAY only.
REQ-010 The module SHALL have ports game_on and menu_on, output, 1 each, drive background/obstacle drawers.
REQ-011 The module SHALL have port mouse_mode, output, 1, 0 = free cursor, 1 = constrained to arena.
REQ-012 The module SHALL have port obstacle_id, output, 3, active pattern index.
REQ-013 The module SHALL have port obstacle_start, output, 1, one-cycle pulse on pattern load.
REQ-014 The module SHALL have port score, output, 16, frames survived.

Function
REQ-015 Each button SHALL pass a two-flop synchronizer, then a rising-edge detector yielding one-cycle pulses game_pe and menu_pe.
REQ-016 frame_tick SHALL be a one-cycle pulse on each vsync_in rising edge, detected against a registered copy.
REQ-017 The FSM SHALL have states MENU, COUNTDOWN, PLAY, OVER.
REQ-018 In MENU the FSM SHALL go to COUNTDOWN on play_selected or game_pe.
REQ-019 In COUNTDOWN the FSM SHALL count frame_tick and go to PLAY on the COUNTDOWN_FRAMES-th tick.
REQ-020 On entry to PLAY the block SHALL set obstacle_id = 0, pulse obstacle_start, clear the frame counter and clear score.
REQ-021 In PLAY, on the OBSTACLE_FRAMES-th tick, obstacle_id SHALL advance modulo NUM_OBSTACLES, wrap from NUM_OBSTACLES-1 to 0, pulse obstacle_start and clear the counter.
REQ-022 In PLAY, collision = 1 SHALL move the FSM to OVER.
REQ-023 In OVER, game_pe SHALL move the FSM to COUNTDOWN.
REQ-024 menu_pe SHALL force MENU from any state, with priority over every other event.
REQ-025 When collision coincides with a pattern switch, collision SHALL win: no obstacle_start, obstacle_id unchanged.
REQ-026 Output decode SHALL be:
- MENU: menu_on = 1, game_on = 0, mouse_mode = 0.
- COUNTDOWN, PLAY, OVER: menu_on = 0, game_on = 1, mouse_mode = 1.
REQ-027 All outputs SHALL be registered, changing one pclk after the qualifying event.
REQ-028 A transition SHALL only occur on a qualifying event, never on a level held across cycles.

Reset
REQ-029 rst SHALL set: state MENU, menu_on = 1, game_on = 0, mouse_mode = 0, obstacle_id = 0, obstacle_start = 0, score = 0, counters 0, sync/edge flops 0.
REQ-030 rst asserted mid-PLAY SHALL take effect on the next pclk edge, with no obstacle_start pulse emitted.

Configuration
REQ-031 With GAME_SCORE_EN defined:
- score SHALL increment on each frame_tick in PLAY, saturating at 16'hFFFF.
- score SHALL hold in OVER.
- score SHALL clear on entry to PLAY and on entry to MENU.
REQ-032 Without GAME_SCORE_EN, score SHALL be constant 0 and no score register SHALL exist.

Structure
REQ-033 Package game_pkg SHALL hold the state enum, MOUSE_FREE/MOUSE_ARENA constants and the arena line constants shared with the drawers and mouse_constrainer.
REQ-034 Sub-module game_edge_detect SHALL be instantiated three times (two buttons, vsync); each instance has a selectable two-flop synchronizer.

Verification (COUNTDOWN_FRAMES=2, OBSTACLE_FRAMES=3, NUM_OBSTACLES=4)
REQ-035 Reset, then a 1-cycle play_selected pulse: next cycle game_on = 1, mouse_mode = 1; after 2 vsync rises, a single obstacle_start with obstacle_id = 0.
REQ-036 In PLAY, 12 vsync rises: obstacle_id steps 1, 2, 3, 0 with one obstacle_start each; score = 12.
REQ-037 collision on the same cycle as the 3rd tick: state OVER, obstacle_id unchanged, no obstacle_start, score frozen.
REQ-038 game_button held high 1000 cycles in OVER: exactly one COUNTDOWN entry; score clears on entry to PLAY.
REQ-039 menu_button edge in PLAY coincident with collision: MENU next cycle, menu_on = 1, mouse_mode = 0.
REQ-040 rst asserted during PLAY with obstacle_id = 2: next cycle all outputs at reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types and constants: FSM state encoding, mouse modes and arena bounds
// used by the controller, the drawers and the mouse constrainer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_MENU      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_OVER      = 2'd3
  } game_state_e;

  localparam logic MOUSE_FREE  = 1'b0;
  localparam logic MOUSE_ARENA = 1'b1;

  localparam logic [10:0] ARENA_LEFT   = 11'd64;
  localparam logic [10:0] ARENA_RIGHT  = 11'd575;
  localparam logic [10:0] ARENA_TOP    = 11'd48;
  localparam logic [10:0] ARENA_BOTTOM = 11'd431;

  // Pattern index after id, wrapping at num-1
  function automatic logic [2:0] next_obstacle(input logic [2:0] id, input int unsigned num);
    return (32'(id) == num - 32'd1) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/game_edge_detect.sv
// Rising-edge detector with optional two-flop synchronizer; pulse_o is a registered
// one-cycle pulse per rising edge of sig_i.
module game_edge_detect #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);

  logic level;
  logic prev_q;
  logic pulse_q;

  if (SYNC_EN) begin : g_sync
    logic s1_q, s2_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= sig_i;
        s2_q <= s1_q;
      end
    end
    assign level = s2_q;
  end else begin : g_nosync
    assign level = sig_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level;
      pulse_q <= level & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Game flow controller: MENU -> COUNTDOWN -> PLAY -> OVER with obstacle sequencing.
// Define GAME_SCORE_EN to build the frames-survived score register.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned OBSTACLE_FRAMES  = 300,
  parameter int unsigned NUM_OBSTACLES    = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        game_button,
  input  logic        menu_button,
  input  logic        play_selected,
  input  logic        collision,
  output logic        game_on,
  output logic        menu_on,
  output logic        mouse_mode,
  output logic [2:0]  obstacle_id,
  output logic        obstacle_start,
  output logic [15:0] score
);

  localparam int unsigned MAX_FRAMES = (COUNTDOWN_FRAMES > OBSTACLE_FRAMES) ?
                                       COUNTDOWN_FRAMES : OBSTACLE_FRAMES;
  localparam int unsigned CNT_W = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] OB_LAST = CNT_W'(OBSTACLE_FRAMES - 1);

  logic game_pe, menu_pe, frame_tick;

  game_edge_detect #(.SYNC_EN(1'b1)) u_game_ed (
    .clk(pclk), .rst(rst), .sig_i(game_button), .pulse_o(game_pe));
  game_edge_detect #(.SYNC_EN(1'b1)) u_menu_ed (
    .clk(pclk), .rst(rst), .sig_i(menu_button), .pulse_o(menu_pe));
  game_edge_detect #(.SYNC_EN(1'b0)) u_vsync_ed (
    .clk(pclk), .rst(rst), .sig_i(vsync_in), .pulse_o(frame_tick));

  game_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       id_q, id_d;
  logic             start_q, start_d;
  logic             menu_on_q, menu_on_d;
  logic             game_on_q, game_on_d;
  logic             mouse_q, mouse_d;
  logic             enter_play;

  always_ff @(posedge pclk) begin
    if (rst) state_q <= ST_MENU;
    else     state_q <= state_d;
  end

  // menu_pe overrides every other event
  always_comb begin
    state_d = state_q;
    if (menu_pe) begin
      state_d = ST_MENU;
    end else begin
      case (state_q)
        ST_MENU:      if (play_selected || game_pe) state_d = ST_COUNTDOWN;
        ST_COUNTDOWN: if (frame_tick && cnt_q == CD_LAST) state_d = ST_PLAY;
        ST_PLAY:      if (collision) state_d = ST_OVER;
        ST_OVER:      if (game_pe) state_d = ST_COUNTDOWN;
        default:      state_d = ST_MENU;
      endcase
    end
  end

  // Leaving PLAY (collision or menu) suppresses the pattern switch on the same tick
  always_comb begin
    menu_on_d  = (state_d == ST_MENU);
    game_on_d  = (state_d != ST_MENU);
    mouse_d    = (state_d == ST_MENU) ? MOUSE_FREE : MOUSE_ARENA;
    enter_play = (state_q == ST_COUNTDOWN) && (state_d == ST_PLAY);
    cnt_d      = cnt_q;
    id_d       = id_q;
    start_d    = 1'b0;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (frame_tick) begin
      if (state_q == ST_COUNTDOWN) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (state_q == ST_PLAY) begin
        if (cnt_q == OB_LAST) begin
          cnt_d   = '0;
          id_d    = next_obstacle(id_q, NUM_OBSTACLES);
          start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    if (enter_play) begin
      id_d    = 3'd0;
      start_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt_q     <= '0;
      id_q      <= 3'd0;
      start_q   <= 1'b0;
      menu_on_q <= 1'b1;
      game_on_q <= 1'b0;
      mouse_q   <= MOUSE_FREE;
    end else begin
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      start_q   <= start_d;
      menu_on_q <= menu_on_d;
      game_on_q <= game_on_d;
      mouse_q   <= mouse_d;
    end
  end

  assign menu_on        = menu_on_q;
  assign game_on        = game_on_q;
  assign mouse_mode     = mouse_q;
  assign obstacle_id    = id_q;
  assign obstacle_start = start_q;

`ifdef GAME_SCORE_EN
  logic [15:0] score_q, score_d;

  // Counts ticks spent in PLAY, saturating; cleared on entering PLAY or MENU
  always_comb begin
    score_d = score_q;
    if (enter_play || (state_d == ST_MENU && state_q != ST_MENU)) begin
      score_d = 16'd0;
    end else if (state_q == ST_PLAY && state_d == ST_PLAY && frame_tick &&
                 score_q != 16'hFFFF) begin
      score_d = score_q + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) score_q <= 16'd0;
    else     score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller with short frame parameters.
module tb_game_controller;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic        game_button = 1'b0;
  logic        menu_button = 1'b0;
  logic        play_selected = 1'b0;
  logic        collision = 1'b0;
  logic        game_on, menu_on, mouse_mode, obstacle_start;
  logic [2:0]  obstacle_id;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;
  int n0;
  logic [2:0] start_ids[$];

`ifdef GAME_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  game_controller #(
    .COUNTDOWN_FRAMES(2),
    .OBSTACLE_FRAMES(3),
    .NUM_OBSTACLES(4)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
    .game_button(game_button), .menu_button(menu_button),
    .play_selected(play_selected), .collision(collision),
    .game_on(game_on), .menu_on(menu_on), .mouse_mode(mouse_mode),
    .obstacle_id(obstacle_id), .obstacle_start(obstacle_start), .score(score)
  );

  always #5 pclk = ~pclk;

  // Log the pattern index carried by every obstacle_start cycle
  always @(posedge pclk) begin
    if (obstacle_start) start_ids.push_back(obstacle_id);
  end

  function automatic logic [31:0] sc(input int v);
    return SCORE_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic vpulse(input int n);
    repeat (n) begin
      vsync_in = 1'b1;
      step(1);
      vsync_in = 1'b0;
      step(1);
    end
  endtask

  initial begin
    // Reset values
    step(3);
    check("rst_menu_on", 32'(menu_on), 32'd1);
    check("rst_game_on", 32'(game_on), 32'd0);
    check("rst_mouse", 32'(mouse_mode), 32'd0);
    check("rst_id", 32'(obstacle_id), 32'd0);
    check("rst_start", 32'(obstacle_start), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    rst = 1'b0;
    step(1);

    // MENU -> COUNTDOWN on a one-cycle play_selected
    play_selected = 1'b1;
    step(1);
    play_selected = 1'b0;
    check("cd_game_on", 32'(game_on), 32'd1);
    check("cd_mouse", 32'(mouse_mode), 32'd1);
    check("cd_menu_on", 32'(menu_on), 32'd0);

    // Two frames of countdown, then a single start with pattern 0
    n0 = start_ids.size();
    vpulse(1);
    step(2);
    check("cd_no_early_start", 32'(start_ids.size() - n0), 32'd0);
    vpulse(1);
    step(2);
    check("play_entry_starts", 32'(start_ids.size() - n0), 32'd1);
    if (start_ids.size() > n0) check("play_entry_id", 32'(start_ids[n0]), 32'd0);
    check("play_entry_score", 32'(score), 32'd0);

    // Twelve PLAY frames: patterns 1,2,3,0
    n0 = start_ids.size();
    vpulse(12);
    step(2);
    check("seq_starts", 32'(start_ids.size() - n0), 32'd4);
    if (start_ids.size() >= n0 + 4) begin
      check("seq_id0", 32'(start_ids[n0]), 32'd1);
      check("seq_id1", 32'(start_ids[n0 + 1]), 32'd2);
      check("seq_id2", 32'(start_ids[n0 + 2]), 32'd3);
      check("seq_id3", 32'(start_ids[n0 + 3]), 32'd0);
    end
    check("seq_score", 32'(score), sc(12));

    // Collision on the switching tick wins
    n0 = start_ids.size();
    vpulse(2);
    vsync_in = 1'b1;
    step(1);
    collision = 1'b1;
    vsync_in = 1'b0;
    step(1);
    collision = 1'b0;
    step(2);
    check("col_no_start", 32'(start_ids.size() - n0), 32'd0);
    check("col_id_kept", 32'(obstacle_id), 32'd0);
    check("col_score", 32'(score), sc(14));
    check("over_game_on", 32'(game_on), 32'd1);
    vpulse(3);
    step(1);
    check("over_no_start", 32'(start_ids.size() - n0), 32'd0);
    check("over_score_frozen", 32'(score), sc(14));

    // Held game_button restarts once; score clears on PLAY entry
    game_button = 1'b1;
    step(1000);
    game_button = 1'b0;
    step(4);
    check("restart_game_on", 32'(game_on), 32'd1);
    check("restart_score_held", 32'(score), sc(14));
    check("restart_no_start", 32'(start_ids.size() - n0), 32'd0);
    vpulse(2);
    step(2);
    check("restart_one_start", 32'(start_ids.size() - n0), 32'd1);
    check("restart_id", 32'(obstacle_id), 32'd0);
    check("restart_score_clr", 32'(score), 32'd0);
    vpulse(1);
    step(1);
    check("restart_score_inc", 32'(score), sc(1));

    // menu_button edge coincident with collision: MENU wins
    menu_button = 1'b1;
    step(3);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    check("menu_menu_on", 32'(menu_on), 32'd1);
    check("menu_game_on", 32'(game_on), 32'd0);
    check("menu_mouse", 32'(mouse_mode), 32'd0);
    check("menu_score", 32'(score), 32'd0);
    menu_button = 1'b0;
    step(4);

    // Reset in PLAY with pattern 2
    play_selected = 1'b1;
    step(1);
    play_selected = 1'b0;
    vpulse(2);
    vpulse(6);
    step(1);
    check("pre_rst_id", 32'(obstacle_id), 32'd2);
    check("pre_rst_score", 32'(score), sc(6));
    n0 = start_ids.size();
    rst = 1'b1;
    step(1);
    check("mid_rst_menu_on", 32'(menu_on), 32'd1);
    check("mid_rst_game_on", 32'(game_on), 32'd0);
    check("mid_rst_mouse", 32'(mouse_mode), 32'd0);
    check("mid_rst_id", 32'(obstacle_id), 32'd0);
    check("mid_rst_start", 32'(obstacle_start), 32'd0);
    check("mid_rst_score", 32'(score), 32'd0);
    rst = 1'b0;
    step(2);
    check("mid_rst_no_pulse", 32'(start_ids.size() - n0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
